// File: rtl/pipefetch_if.sv
// Instruction-memory read port shared by the fetch stage and the memory model.
// imem_ack may rise in the same cycle as imem_req.
interface pipefetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/pipefetch.sv
// Instruction fetch stage: issues imem reads, fills the IF/ID register, and keeps a
// one-entry skid buffer for a word that returns while decode is stalled.
module pipefetch #(
    parameter logic [31:0] BUBBLE_PC = 32'hFFFF_FFFC
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [31:0]         pc,
    input  logic                wpcir,
    input  logic                flush,
    pipefetch_if.master         imem,
    output logic                fstall,
    output logic [31:0]         dinst,
    output logic [31:0]         dpc4,
    output logic                dvalid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] bufinst;
    logic [31:0] bufpc4;
    logic [31:0] pc4;
    logic        req;
    logic        got;

    assign pc4 = pc + 32'd4;

    // Request only from FETCH with a real PC; reset and flush both suppress it.
    always_comb begin
        req = 1'b0;
        if (resetn && !flush && state == FETCH && pc != BUBBLE_PC)
            req = 1'b1;
    end

    assign got            = req && imem.imem_ack;
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    always_comb begin
        fstall = 1'b0;
        if (resetn && !flush) begin
            if (state == HOLD)
                fstall = wpcir;
            else if (req)
                fstall = imem.imem_ack ? wpcir : 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= FETCH;
            dinst   <= '0;
            dpc4    <= '0;
            dvalid  <= 1'b0;
            bufinst <= '0;
            bufpc4  <= '0;
        end else if (flush) begin
            state   <= FETCH;
            dvalid  <= 1'b0;
            bufinst <= '0;
            bufpc4  <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (got && !wpcir) begin
                        dinst  <= imem.imem_rdata;
                        dpc4   <= pc4;
                        dvalid <= 1'b1;
                    end else if (got) begin
                        bufinst <= imem.imem_rdata;
                        bufpc4  <= pc4;
                        state   <= HOLD;
                    end else if (!wpcir) begin
                        // Waiting on memory or idle PC: decode moves on, so it sees a bubble.
                        dvalid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!wpcir) begin
                        dinst  <= bufinst;
                        dpc4   <= bufpc4;
                        dvalid <= 1'b1;
                        state  <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pipefetch.sv
// Directed bench for pipefetch: reset, wait states, stall capture, flush and async reset.
module tb_pipefetch;

    logic        clock;
    logic        resetn;
    logic [31:0] pc;
    logic        wpcir;
    logic        flush;
    logic        fstall;
    logic [31:0] dinst;
    logic [31:0] dpc4;
    logic        dvalid;
    int unsigned n_cmp;
    int unsigned n_err;

    pipefetch_if mif ();

    pipefetch #(.BUBBLE_PC(32'hFFFF_FFFC)) dut (
        .clock  (clock),
        .resetn (resetn),
        .pc     (pc),
        .wpcir  (wpcir),
        .flush  (flush),
        .imem   (mif),
        .fstall (fstall),
        .dinst  (dinst),
        .dpc4   (dpc4),
        .dvalid (dvalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetn = 1'b0;
        pc = 32'hFFFF_FFFC;
        wpcir = 1'b0;
        flush = 1'b0;
        mif.imem_ack = 1'b0;
        mif.imem_rdata = '0;
        #3;
        check("rst_dvalid", {31'd0, dvalid}, 32'd0);
        check("rst_dinst", dinst, 32'd0);
        check("rst_dpc4", dpc4, 32'd0);
        pc = 32'h0;
        mif.imem_ack = 1'b1;
        #1;
        check("rst_req", {31'd0, mif.imem_req}, 32'd0);
        check("rst_fstall", {31'd0, fstall}, 32'd0);
        pc = 32'hFFFF_FFFC;
        step();
        step();
        resetn = 1'b1;

        // Reset release: bubble PC first, then fetch at 0
        mif.imem_rdata = 32'h2001_0005;
        #1;
        check("rr_req_bubble", {31'd0, mif.imem_req}, 32'd0);
        check("rr_fstall_bubble", {31'd0, fstall}, 32'd0);
        step();
        check("rr_dvalid0", {31'd0, dvalid}, 32'd0);
        pc = 32'h0;
        #1;
        check("rr_req", {31'd0, mif.imem_req}, 32'd1);
        check("rr_addr", mif.imem_addr, 32'h0);
        check("rr_fstall", {31'd0, fstall}, 32'd0);
        step();
        check("rr_dinst", dinst, 32'h2001_0005);
        check("rr_dpc4", dpc4, 32'h4);
        check("rr_dvalid", {31'd0, dvalid}, 32'd1);

        // Memory wait: two cycles without ack
        pc = 32'h8;
        mif.imem_ack = 1'b0;
        mif.imem_rdata = 32'h8C22_0000;
        #1;
        check("mw_fstall0", {31'd0, fstall}, 32'd1);
        check("mw_addr", mif.imem_addr, 32'h8);
        step();
        check("mw_dvalid1", {31'd0, dvalid}, 32'd0);
        check("mw_fstall1", {31'd0, fstall}, 32'd1);
        step();
        check("mw_dvalid2", {31'd0, dvalid}, 32'd0);
        mif.imem_ack = 1'b1;
        #1;
        check("mw_fstall_ack", {31'd0, fstall}, 32'd0);
        step();
        check("mw_dinst", dinst, 32'h8C22_0000);
        check("mw_dpc4", dpc4, 32'hC);
        check("mw_dvalid", {31'd0, dvalid}, 32'd1);

        // Stall capture into skid buffer
        pc = 32'h10;
        mif.imem_rdata = 32'hAAAA_0010;
        wpcir = 1'b1;
        #1;
        check("sc_fstall_cap", {31'd0, fstall}, 32'd1);
        check("sc_req_cap", {31'd0, mif.imem_req}, 32'd1);
        step();
        mif.imem_rdata = 32'hBBBB_BBBB;
        #1;
        check("sc_req_hold", {31'd0, mif.imem_req}, 32'd0);
        check("sc_fstall_hold", {31'd0, fstall}, 32'd1);
        check("sc_dinst_hold", dinst, 32'h8C22_0000);
        step();
        check("sc_dpc4_hold", dpc4, 32'hC);
        step();
        check("sc_dinst_hold3", dinst, 32'h8C22_0000);
        wpcir = 1'b0;
        #1;
        check("sc_fstall_rel", {31'd0, fstall}, 32'd0);
        step();
        check("sc_dinst", dinst, 32'hAAAA_0010);
        check("sc_dpc4", dpc4, 32'h14);
        check("sc_dvalid", {31'd0, dvalid}, 32'd1);
        pc = 32'h14;
        mif.imem_ack = 1'b0;
        #1;
        check("sc_back_fetch", {31'd0, mif.imem_req}, 32'd1);

        // Flush while holding a buffered word
        pc = 32'h18;
        mif.imem_ack = 1'b1;
        mif.imem_rdata = 32'hCCCC_0018;
        wpcir = 1'b1;
        step();
        check("fl_in_hold", {31'd0, mif.imem_req}, 32'd0);
        flush = 1'b1;
        #1;
        check("fl_fstall", {31'd0, fstall}, 32'd0);
        check("fl_req", {31'd0, mif.imem_req}, 32'd0);
        step();
        check("fl_dvalid", {31'd0, dvalid}, 32'd0);
        flush = 1'b0;
        wpcir = 1'b0;
        pc = 32'hFFFF_FFFC;
        step();
        check("fl_dvalid_after", {31'd0, dvalid}, 32'd0);
        check("fl_no_bufword", {31'd0, dinst == 32'hCCCC_0018}, 32'd0);
        pc = 32'h20;
        #1;
        check("fl_state_fetch", {31'd0, mif.imem_req}, 32'd1);

        // Flush in FETCH overrides a same-cycle ack
        mif.imem_rdata = 32'hDDDD_0020;
        flush = 1'b1;
        #1;
        check("ff_req", {31'd0, mif.imem_req}, 32'd0);
        check("ff_fstall", {31'd0, fstall}, 32'd0);
        step();
        check("ff_dvalid", {31'd0, dvalid}, 32'd0);
        flush = 1'b0;

        // Ack with no request is ignored
        pc = 32'hFFFF_FFFC;
        step();
        check("ign_dvalid", {31'd0, dvalid}, 32'd0);

        // Wait state under decode stall keeps IF/ID, then bubble once stall drops
        pc = 32'h20;
        mif.imem_rdata = 32'h1111_0020;
        step();
        check("ws_dinst", dinst, 32'h1111_0020);
        check("ws_dpc4", dpc4, 32'h24);
        pc = 32'h24;
        mif.imem_ack = 1'b0;
        wpcir = 1'b1;
        #1;
        check("ws_fstall", {31'd0, fstall}, 32'd1);
        step();
        check("ws_dvalid_kept", {31'd0, dvalid}, 32'd1);
        check("ws_dinst_kept", dinst, 32'h1111_0020);
        wpcir = 1'b0;
        step();
        check("ws_dvalid_bubble", {31'd0, dvalid}, 32'd0);

        // Async reset mid-wait
        pc = 32'h28;
        mif.imem_ack = 1'b1;
        mif.imem_rdata = 32'h2222_0028;
        step();
        check("ar_pre_dvalid", {31'd0, dvalid}, 32'd1);
        pc = 32'h2C;
        mif.imem_ack = 1'b0;
        step();
        #1;
        resetn = 1'b0;
        #1;
        check("ar_dvalid", {31'd0, dvalid}, 32'd0);
        check("ar_dinst", dinst, 32'd0);
        check("ar_dpc4", dpc4, 32'd0);
        check("ar_req", {31'd0, mif.imem_req}, 32'd0);
        check("ar_fstall", {31'd0, fstall}, 32'd0);
        step();
        resetn = 1'b1;
        pc = 32'hFFFF_FFFC;
        step();
        check("ar_post_dvalid", {31'd0, dvalid}, 32'd0);

        // Async reset in HOLD loses the buffered word
        pc = 32'h30;
        mif.imem_ack = 1'b1;
        mif.imem_rdata = 32'h3333_0030;
        wpcir = 1'b1;
        step();
        #2;
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        pc = 32'hFFFF_FFFC;
        wpcir = 1'b0;
        #1;
        check("arh_fstall", {31'd0, fstall}, 32'd0);
        step();
        check("arh_dvalid", {31'd0, dvalid}, 32'd0);
        check("arh_dinst", dinst, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
